// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, status codes and PS/2 byte constants for the command sequencer
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_LACK,
        S_WAIT_RESP,
        S_DONE
    } ps2_state_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'b00,
        STAT_NACK    = 2'b01,
        STAT_TIMEOUT = 2'b10
    } ps2_status_e;

    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_SET_LED = 8'hED;
    localparam logic [7:0] PS2_BREAK   = 8'hF0;
    localparam logic [7:0] PS2_EXT     = 8'hE0;

endpackage

// File: rtl/ps2_edge_sync.sv
// rtl/ps2_edge_sync.sv - 2-flop synchronizer with falling-edge detect for a raw PS/2 line
module ps2_edge_sync (
    input  logic clk,    // system clock
    input  logic rst_n,  // async active-low reset
    input  logic din,    // raw asynchronous line
    output logic level,  // synchronized level
    output logic fall    // one-cycle pulse on synchronized 1 -> 0
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// rtl/ps2_cmd_ctrl.sv - host-side PS/2 command sequencer with resend, timeout and scan-code forwarding
module ps2_cmd_ctrl #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,          // system clock
    input  logic       rst_n,        // async active-low reset
    input  logic       cmd_valid,    // command request
    output logic       cmd_ready,    // idle, accepting a command
    input  logic [7:0] cmd_byte,     // command byte
    input  logic       cmd_has_arg,  // argument byte follows
    input  logic [7:0] cmd_arg,      // argument byte
    output logic       done,         // one-cycle completion pulse
    output logic [1:0] status,       // result while done is high
    input  logic       ps2_clk_in,   // raw PS/2 clock line
    input  logic       ps2_data_in,  // raw PS/2 data line
    output logic       ps2_clk_oe,   // 1 pulls clock low
    output logic       ps2_data_oe,  // 1 pulls data low
    input  logic [9:0] rx_code,      // receiver {expand, break, byte}
    input  logic       rx_ready,     // receiver strobe
    output logic       rx_rst,       // receiver reset while host drives
    output logic [9:0] key_code,     // forwarded scan code
    output logic       key_valid     // forwarded-code strobe
);

    import ps2_pkg::*;

    localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int RTR_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // Loads are N-1 so that the counter reaches zero on the Nth cycle.
    localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [RTR_W-1:0]  retry_q, retry_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        arg_q, arg_d;
    logic              pend_q, pend_d;
    logic              clk_oe_q, clk_oe_d;
    logic              data_oe_q, data_oe_d;
    logic              rx_rst_q, rx_rst_d;
    ps2_status_e       status_q, status_d;
    logic [9:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;

    logic clk_fall;
    logic clk_lvl_unused;
    logic data_lvl;
    logic data_fall_unused;

    ps2_edge_sync u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2_clk_in),
        .level (clk_lvl_unused),
        .fall  (clk_fall)
    );

    ps2_edge_sync u_data_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2_data_in),
        .level (data_lvl),
        .fall  (data_fall_unused)
    );

    logic rx_ack;
    logic rx_rsnd;
    logic expired;
    logic can_retry;

    assign rx_ack    = rx_ready && (rx_code == {2'b00, PS2_ACK});
    assign rx_rsnd   = rx_ready && (rx_code == {2'b00, PS2_RESEND});
    assign expired   = (cnt_q == '0);
    assign can_retry = (retry_q < RTR_W'(MAX_RETRY));

    always_comb begin
        state_d     = state_q;
        cnt_d       = expired ? cnt_q : cnt_q - CNT_W'(1);
        bit_d       = bit_q;
        retry_d     = retry_q;
        byte_d      = byte_q;
        arg_d       = arg_q;
        pend_d      = pend_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        rx_rst_d    = rx_rst_q;
        status_d    = status_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    byte_d   = cmd_byte;
                    arg_d    = cmd_arg;
                    pend_d   = cmd_has_arg;
                    retry_d  = '0;
                    state_d  = S_INHIBIT;
                    cnt_d    = INH_LOAD;
                    clk_oe_d = 1'b1;
                    rx_rst_d = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (expired) begin
                    data_oe_d = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                clk_oe_d = 1'b0;
                bit_d    = 4'd0;
                cnt_d    = TMO_LOAD;
                state_d  = S_SEND;
            end
            S_SEND: begin
                // An edge always takes priority over a coincident timeout.
                if (clk_fall) begin
                    cnt_d = TMO_LOAD;
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        data_oe_d = ~byte_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        // Odd parity bit; drive low only when the bit is 0.
                        data_oe_d = ^byte_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_LACK;
                    end
                end else if (expired) begin
                    state_d   = S_DONE;
                    status_d  = STAT_TIMEOUT;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    rx_rst_d  = 1'b0;
                end
            end
            S_LACK: begin
                if (clk_fall) begin
                    cnt_d = TMO_LOAD;
                    if (!data_lvl) begin
                        rx_rst_d = 1'b0;
                        state_d  = S_WAIT_RESP;
                    end else if (can_retry) begin
                        retry_d   = retry_q + RTR_W'(1);
                        state_d   = S_INHIBIT;
                        cnt_d     = INH_LOAD;
                        clk_oe_d  = 1'b1;
                        data_oe_d = 1'b0;
                        rx_rst_d  = 1'b1;
                    end else begin
                        state_d   = S_DONE;
                        status_d  = STAT_NACK;
                        clk_oe_d  = 1'b0;
                        data_oe_d = 1'b0;
                        rx_rst_d  = 1'b0;
                    end
                end else if (expired) begin
                    state_d   = S_DONE;
                    status_d  = STAT_TIMEOUT;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    rx_rst_d  = 1'b0;
                end
            end
            S_WAIT_RESP: begin
                if (rx_ack) begin
                    if (pend_q) begin
                        byte_d    = arg_q;
                        pend_d    = 1'b0;
                        retry_d   = '0;
                        state_d   = S_INHIBIT;
                        cnt_d     = INH_LOAD;
                        clk_oe_d  = 1'b1;
                        data_oe_d = 1'b0;
                        rx_rst_d  = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        status_d = STAT_OK;
                    end
                end else if (rx_rsnd) begin
                    if (can_retry) begin
                        retry_d   = retry_q + RTR_W'(1);
                        state_d   = S_INHIBIT;
                        cnt_d     = INH_LOAD;
                        clk_oe_d  = 1'b1;
                        data_oe_d = 1'b0;
                        rx_rst_d  = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        status_d = STAT_NACK;
                    end
                end else if (expired) begin
                    state_d   = S_DONE;
                    status_d  = STAT_TIMEOUT;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    rx_rst_d  = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While the receiver is held in reset its strobes are meaningless and dropped.
        if (rx_ready && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                         ((state_q == S_WAIT_RESP) && !rx_ack && !rx_rsnd))) begin
            key_valid_d = 1'b1;
            key_code_d  = rx_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= 4'd0;
            retry_q     <= '0;
            byte_q      <= 8'h00;
            arg_q       <= 8'h00;
            pend_q      <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            rx_rst_q    <= 1'b0;
            status_q    <= STAT_OK;
            key_code_q  <= 10'h000;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            retry_q     <= retry_d;
            byte_q      <= byte_d;
            arg_q       <= arg_d;
            pend_q      <= pend_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            rx_rst_q    <= rx_rst_d;
            status_q    <= status_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign status      = status_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign rx_rst      = rx_rst_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// tb/tb_ps2_cmd_ctrl.sv - scoreboard bench for ps2_cmd_ctrl with a PS/2 device and receiver model
module tb_ps2_cmd_ctrl;

    import ps2_pkg::*;

    localparam int INH   = 20;
    localparam int TMO   = 200;
    localparam int RETRY = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_has_arg = 1'b0;
    logic [7:0] cmd_arg = 8'h00;
    logic       done;
    logic [1:0] status;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic [9:0] rx_code = 10'h000;
    logic       rx_ready = 1'b0;
    logic       rx_rst;
    logic [9:0] key_code;
    logic       key_valid;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_cmd_ctrl #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (RETRY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_byte    (cmd_byte),
        .cmd_has_arg (cmd_has_arg),
        .cmd_arg     (cmd_arg),
        .done        (done),
        .status      (status),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_code     (rx_code),
        .rx_ready    (rx_ready),
        .rx_rst      (rx_rst),
        .key_code    (key_code),
        .key_valid   (key_valid)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_st[$];
    logic [9:0] exp_key[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_st.size() == 0) chk("unexpected_done", done, 0);
                else                    chk("status", status, exp_st.pop_front());
            end
            if (key_valid) begin
                if (exp_key.size() == 0) chk("unexpected_key", key_valid, 0);
                else                     chk("key_code", key_code, exp_key.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [7:0] b, input logic has, input logic [7:0] a);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_byte    = b;
        cmd_has_arg = has;
        cmd_arg     = a;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("start_wait", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    // Device clocks 11 edges; frame is {stop, parity, byte} as seen on the line.
    task automatic dev_transfer(input logic [9:0] exp_frame, input logic line_ack, input string tag);
        logic [9:0] rec;
        rec = '0;
        wait_start();
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && line_ack) dev_data = 1'b0;
            repeat (2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            if (i < 10) rec[i] = ps2_data_in;
            if (i == 5) chk("rx_rst_send", rx_rst, 1);
            if (i == 10 && line_ack) chk("rx_rst_after_ack", rx_rst, 0);
            dev_clk = 1'b1;
            repeat (10) @(negedge clk);
            dev_data = 1'b1;
        end
        chk(tag, rec, exp_frame);
    endtask

    task automatic rx_send(input logic [9:0] code);
        rx_code  = code;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset values
        #23;
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_rx_rst", rx_rst, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_code", key_code, 0);

        // 0xED + 0x02, clean line-ACKs and FA replies
        exp_st.push_back(STAT_OK);
        send_cmd(8'hED, 1'b1, 8'h02);
        chk("rx_rst_inhibit", rx_rst, 1);
        chk("clk_oe_inhibit", ps2_clk_oe, 1);
        rx_send(10'h0AA);
        chk("drop_in_inhibit", key_valid, 0);
        dev_transfer(10'h3ED, 1'b1, "frame_ED");
        chk("rx_rst_wait_resp", rx_rst, 0);
        rx_send({2'b00, 8'hFA});
        chk("no_done_first_byte", done, 0);
        chk("rx_rst_second_byte", rx_rst, 1);
        dev_transfer(10'h202, 1'b1, "frame_02");
        rx_send({2'b00, 8'hFA});
        chk("done_latency", done, 1);
        chk("rx_rst_after_done", rx_rst, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        // 0xF4 answered FE three times -> NACK
        exp_st.push_back(STAT_NACK);
        send_cmd(8'hF4, 1'b0, 8'h00);
        for (int r = 0; r < 3; r++) begin
            dev_transfer(10'h2F4, 1'b1, "frame_F4");
            rx_send({2'b00, 8'hFE});
        end
        chk("nack_done", done, 1);

        // 0xF6 with missing line-ACK three times -> NACK
        exp_st.push_back(STAT_NACK);
        send_cmd(8'hF6, 1'b0, 8'h00);
        for (int r = 0; r < 3; r++) dev_transfer(10'h3F6, 1'b0, "frame_F6");
        repeat (5) @(negedge clk);

        // 0xF5: scan code 0x1C arrives before FA and is forwarded
        exp_st.push_back(STAT_OK);
        send_cmd(8'hF5, 1'b0, 8'h00);
        dev_transfer(10'h3F5, 1'b1, "frame_F5");
        exp_key.push_back(10'h01C);
        rx_send(10'h01C);
        chk("fwd_latency", key_valid, 1);
        chk("fwd_not_consumed", done, 0);
        rx_send({2'b00, 8'hFA});
        chk("done_after_fwd", done, 1);
        repeat (2) @(negedge clk);
        exp_key.push_back(10'h0FA);
        rx_send(10'h0FA);
        chk("fwd_idle_fa", key_valid, 1);

        // 0xFF: device never clocks -> TIMEOUT exactly TMO+1 cycles after START
        exp_st.push_back(STAT_TIMEOUT);
        send_cmd(8'hFF, 1'b0, 8'h00);
        n = 0;
        while (!(ps2_clk_oe && ps2_data_oe) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, TMO + 1);
        chk("timeout_release", {ps2_clk_oe, ps2_data_oe, rx_rst}, 3'b000);

        // Reset at SEND edge 5 of 0xED
        send_cmd(8'hED, 1'b0, 8'h00);
        wait_start();
        for (int i = 0; i < 5; i++) begin
            repeat (2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            if (i < 4) begin
                dev_clk = 1'b1;
                repeat (10) @(negedge clk);
            end
        end
        chk("pre_reset_data_oe", ps2_data_oe, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_release", {ps2_clk_oe, ps2_data_oe, rx_rst}, 3'b000);
        dev_clk = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1);
        repeat (30) @(negedge clk);

        chk("scoreboard_empty", exp_st.size() + exp_key.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
